uart_fifo_core: RTL and testbench

- Next-generation UART block: configurable frame format (data bits, parity, stop bits) and a FIFO on each direction.
- Application side writes and reads through FIFOs instead of a single-byte start/valid handshake.
- Received bytes carry per-entry parity and framing error flags; a sticky overrun flag reports dropped bytes.
- Sits between the board UART pins and application logic. Self-contained TX and RX engines.

---
 rtl/uart_fifo_core.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_core.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_core.sv
// uart_fifo_core
//   UART with a configurable frame format and a first-word-fall-through FIFO
//   in each direction. The TX engine drains the TX FIFO onto uart_tx. The RX
//   engine deserialises uart_rx and pushes {frame_err, parity_err, data}
//   entries into the RX FIFO.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   uart_rx         asynchronous serial input, idle high
//   uart_tx         serial output, idle high
//   tx_data, tx_wr  byte to queue and its push strobe
//   tx_full         TX FIFO full
//   tx_busy         TX FIFO non-empty or a frame is on the line
//   rx_data         RX FIFO head data, zero-extended, 0 when empty
//   rx_parity_err   parity error flag of the RX head entry
//   rx_frame_err    framing error flag of the RX head entry
//   rx_empty        RX FIFO empty
//   rx_rd           pop the RX head
//   rx_overrun      sticky flag: a received frame was dropped
//   rx_overrun_clr  clear rx_overrun (a same-cycle set wins)
module uart_fifo_core #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       uart_tx,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_full,
  output logic       tx_busy,
  output logic [7:0] rx_data,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       rx_empty,
  input  logic       rx_rd,
  output logic       rx_overrun,
  input  logic       rx_overrun_clr
);

  localparam int CPB   = CLOCK_FREQ / BAUD;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(STOP_BITS * CPB + 1);
  localparam int RX_W  = DATA_BITS + 2;

  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] STOP_END = CNT_W'(STOP_BITS * CPB - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic             ODD      = (PARITY == 1);
  localparam bit               HAS_PAR  = (PARITY != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] txMem_q [FIFO_DEPTH];
  logic [AW:0]          txWrPtr_q, txRdPtr_q;
  logic                 txEmpty, txFullInt, txPush, txPop;
  logic [DATA_BITS-1:0] txHead;

  assign txEmpty   = (txWrPtr_q == txRdPtr_q);
  assign txFullInt = (txWrPtr_q[AW] != txRdPtr_q[AW]) &&
                     (txWrPtr_q[AW-1:0] == txRdPtr_q[AW-1:0]);
  // A pop in the same cycle frees the slot, so a push at full is then legal.
  assign txPush    = tx_wr && (!txFullInt || txPop);
  assign txHead    = txMem_q[txRdPtr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      txWrPtr_q <= '0;
      txRdPtr_q <= '0;
    end else begin
      if (txPush) begin
        txMem_q[txWrPtr_q[AW-1:0]] <= tx_data[DATA_BITS-1:0];
        txWrPtr_q <= txWrPtr_q + 1'b1;
      end
      if (txPop) txRdPtr_q <= txRdPtr_q + 1'b1;
    end
  end

  // ---------------- TX engine ----------------
  state_e               txState_q, txState_d;
  logic [CNT_W-1:0]     txCnt_q, txCnt_d;
  logic [2:0]           txBit_q, txBit_d;
  logic [DATA_BITS-1:0] txShift_q, txShift_d;
  logic                 txPar_q, txPar_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      txState_q <= S_IDLE;
      txCnt_q   <= '0;
      txBit_q   <= '0;
      txShift_q <= '0;
      txPar_q   <= 1'b0;
    end else begin
      txState_q <= txState_d;
      txCnt_q   <= txCnt_d;
      txBit_q   <= txBit_d;
      txShift_q <= txShift_d;
      txPar_q   <= txPar_d;
    end
  end

  always_comb begin
    txState_d = txState_q;
    txCnt_d   = txCnt_q + 1'b1;
    txBit_d   = txBit_q;
    txShift_d = txShift_q;
    txPar_d   = txPar_q;
    txPop     = 1'b0;
    case (txState_q)
      S_IDLE: begin
        txCnt_d = '0;
        if (!txEmpty) begin
          txPop     = 1'b1;
          txShift_d = txHead;
          txPar_d   = (^txHead) ^ ODD;
          txState_d = S_START;
        end
      end
      S_START: begin
        if (txCnt_q == BIT_END) begin
          txCnt_d   = '0;
          txBit_d   = '0;
          txState_d = S_DATA;
        end
      end
      S_DATA: begin
        if (txCnt_q == BIT_END) begin
          txCnt_d   = '0;
          txShift_d = txShift_q >> 1;
          txBit_d   = txBit_q + 1'b1;
          if (txBit_q == LAST_BIT) txState_d = HAS_PAR ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (txCnt_q == BIT_END) begin
          txCnt_d   = '0;
          txState_d = S_STOP;
        end
      end
      S_STOP: begin
        if (txCnt_q == STOP_END) begin
          txCnt_d   = '0;
          txState_d = S_IDLE;
        end
      end
      default: txState_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (txState_q)
      S_START:  uart_tx = 1'b0;
      S_DATA:   uart_tx = txShift_q[0];
      S_PARITY: uart_tx = txPar_q;
      default:  uart_tx = 1'b1;
    endcase
  end

  assign tx_full = txFullInt;
  assign tx_busy = (txState_q != S_IDLE) || !txEmpty;

  // ---------------- RX synchroniser ----------------
  // rxPrev_q is one more stage used only for falling-edge detection.
  logic rxMeta_q, rxSync_q, rxPrev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      rxMeta_q <= uart_rx;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= rxSync_q;
    end
  end

  // ---------------- RX engine ----------------
  state_e               rxState_q, rxState_d;
  logic [CNT_W-1:0]     rxCnt_q, rxCnt_d;
  logic [2:0]           rxBit_q, rxBit_d;
  logic [DATA_BITS-1:0] rxShift_q, rxShift_d;
  logic                 rxParErr_q, rxParErr_d;
  logic                 rxPushReq;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxState_q  <= S_IDLE;
      rxCnt_q    <= '0;
      rxBit_q    <= '0;
      rxShift_q  <= '0;
      rxParErr_q <= 1'b0;
    end else begin
      rxState_q  <= rxState_d;
      rxCnt_q    <= rxCnt_d;
      rxBit_q    <= rxBit_d;
      rxShift_q  <= rxShift_d;
      rxParErr_q <= rxParErr_d;
    end
  end

  always_comb begin
    rxState_d  = rxState_q;
    rxCnt_d    = rxCnt_q + 1'b1;
    rxBit_d    = rxBit_q;
    rxShift_d  = rxShift_q;
    rxParErr_d = rxParErr_q;
    rxPushReq  = 1'b0;
    case (rxState_q)
      S_IDLE: begin
        rxCnt_d = '0;
        if (rxPrev_q && !rxSync_q) begin
          rxParErr_d = 1'b0;
          rxState_d  = S_START;
        end
      end
      S_START: begin
        // Mid-start sample; a high level here means the edge was a glitch.
        if (rxCnt_q == HALF_END) begin
          rxCnt_d   = '0;
          rxBit_d   = '0;
          rxState_d = rxSync_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rxCnt_q == BIT_END) begin
          rxCnt_d   = '0;
          rxShift_d = {rxSync_q, rxShift_q[DATA_BITS-1:1]};
          rxBit_d   = rxBit_q + 1'b1;
          if (rxBit_q == LAST_BIT) rxState_d = HAS_PAR ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (rxCnt_q == BIT_END) begin
          rxCnt_d    = '0;
          rxParErr_d = rxSync_q ^ ((^rxShift_q) ^ ODD);
          rxState_d  = S_STOP;
        end
      end
      S_STOP: begin
        if (rxCnt_q == BIT_END) begin
          rxCnt_d   = '0;
          rxPushReq = 1'b1;
          rxState_d = S_IDLE;
        end
      end
      default: rxState_d = S_IDLE;
    endcase
  end

  // ---------------- RX FIFO ----------------
  logic [RX_W-1:0] rxMem_q [FIFO_DEPTH];
  logic [AW:0]     rxWrPtr_q, rxRdPtr_q;
  logic            rxEmptyInt, rxFullInt, rxPush, rxPop, rxOverrun_q;
  logic [RX_W-1:0] rxEntry, rxHead;
  logic [7:0]      rxDataExt;

  assign rxEmptyInt = (rxWrPtr_q == rxRdPtr_q);
  assign rxFullInt  = (rxWrPtr_q[AW] != rxRdPtr_q[AW]) &&
                      (rxWrPtr_q[AW-1:0] == rxRdPtr_q[AW-1:0]);
  assign rxPop      = rx_rd && !rxEmptyInt;
  assign rxPush     = rxPushReq && (!rxFullInt || rxPop);
  assign rxEntry    = {~rxSync_q, rxParErr_q, rxShift_q};
  assign rxHead     = rxMem_q[rxRdPtr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      rxWrPtr_q   <= '0;
      rxRdPtr_q   <= '0;
      rxOverrun_q <= 1'b0;
    end else begin
      if (rxPush) begin
        rxMem_q[rxWrPtr_q[AW-1:0]] <= rxEntry;
        rxWrPtr_q <= rxWrPtr_q + 1'b1;
      end
      if (rxPop) rxRdPtr_q <= rxRdPtr_q + 1'b1;
      if (rxPushReq && !rxPush) rxOverrun_q <= 1'b1;
      else if (rx_overrun_clr)  rxOverrun_q <= 1'b0;
    end
  end

  // Outputs are forced to zero while empty so stale memory never shows.
  always_comb begin
    rxDataExt = '0;
    if (!rxEmptyInt) rxDataExt[DATA_BITS-1:0] = rxHead[DATA_BITS-1:0];
  end

  assign rx_data       = rxDataExt;
  assign rx_parity_err = !rxEmptyInt && rxHead[DATA_BITS];
  assign rx_frame_err  = !rxEmptyInt && rxHead[DATA_BITS+1];
  assign rx_empty      = rxEmptyInt;
  assign rx_overrun    = rxOverrun_q;

endmodule

// File: tb/tb_uart_fifo_core.sv
// Testbench for uart_fifo_core. Two instances at CPB=10, FIFO_DEPTH=4:
// u0 is 8N1, u1 is 8E2 and can loop its uart_tx back to its uart_rx.
// A background monitor decodes frames on a selectable TX line into monQ.
module tb_uart_fifo_core;

  localparam int CF    = 1000000;
  localparam int BR    = 100000;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       rx0Drive = 1'b1, rx1Drive = 1'b1, loop1 = 1'b0;
  logic       tx0, tx1, rx1Line;
  logic [7:0] txData0 = '0, txData1 = '0;
  logic       txWr0 = 1'b0, txWr1 = 1'b0;
  logic       txFull0, txFull1, txBusy0, txBusy1;
  logic [7:0] rxData0, rxData1;
  logic       rxPerr0, rxPerr1, rxFerr0, rxFerr1, rxEmpty0, rxEmpty1;
  logic       rxRd0 = 1'b0, rxRd1 = 1'b0;
  logic       ovr0, ovr1;
  logic       ovrClr0 = 1'b0, ovrClr1 = 1'b0;

  int total = 0;
  int bad   = 0;

  logic       monSel = 1'b0, monHasPar = 1'b0;
  int         monStops = 1;
  logic       monLine;
  logic [9:0] monQ[$];

  assign rx1Line = loop1 ? tx1 : rx1Drive;
  assign monLine = monSel ? tx1 : tx0;

  always #5 clk = ~clk;

  uart_fifo_core #(
    .CLOCK_FREQ(CF), .BAUD(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
  ) u0 (
    .clk(clk), .rst(rst), .uart_rx(rx0Drive), .uart_tx(tx0),
    .tx_data(txData0), .tx_wr(txWr0), .tx_full(txFull0), .tx_busy(txBusy0),
    .rx_data(rxData0), .rx_parity_err(rxPerr0), .rx_frame_err(rxFerr0),
    .rx_empty(rxEmpty0), .rx_rd(rxRd0), .rx_overrun(ovr0), .rx_overrun_clr(ovrClr0)
  );

  uart_fifo_core #(
    .CLOCK_FREQ(CF), .BAUD(BR), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)
  ) u1 (
    .clk(clk), .rst(rst), .uart_rx(rx1Line), .uart_tx(tx1),
    .tx_data(txData1), .tx_wr(txWr1), .tx_full(txFull1), .tx_busy(txBusy1),
    .rx_data(rxData1), .rx_parity_err(rxPerr1), .rx_frame_err(rxFerr1),
    .rx_empty(rxEmpty1), .rx_rd(rxRd1), .rx_overrun(ovr1), .rx_overrun_clr(ovrClr1)
  );

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One-cycle tx_wr pulse; consecutive calls give back-to-back writes.
  task automatic applyTxWrite(input int which, input logic [7:0] d);
    if (which == 0) begin txData0 = d; txWr0 = 1'b1; end
    else            begin txData1 = d; txWr1 = 1'b1; end
    @(negedge clk);
    txWr0 = 1'b0;
    txWr1 = 1'b0;
  endtask

  task automatic holdRxBit(input int which, input logic v);
    if (which == 0) rx0Drive = v;
    else            rx1Drive = v;
    repeat (10) @(negedge clk);
  endtask

  // Drives one serial frame (one stop bit) followed by one idle bit time.
  task automatic applyRxFrame(input int which, input logic [7:0] d, input logic hasPar,
                              input logic parBit, input logic stopBit);
    holdRxBit(which, 1'b0);
    for (int i = 0; i < 8; i++) holdRxBit(which, d[i]);
    if (hasPar) holdRxBit(which, parBit);
    holdRxBit(which, stopBit);
    holdRxBit(which, 1'b1);
  endtask

  task automatic applyRxPop(input int which);
    if (which == 0) rxRd0 = 1'b1;
    else            rxRd1 = 1'b1;
    @(negedge clk);
    rxRd0 = 1'b0;
    rxRd1 = 1'b0;
  endtask

  task automatic checkHead(input string tag, input int which, input logic [7:0] d,
                           input logic perr, input logic ferr);
    checkOutput({tag, " data"},  (which == 0) ? rxData0  : rxData1,  d);
    checkOutput({tag, " perr"},  (which == 0) ? rxPerr0  : rxPerr1,  perr);
    checkOutput({tag, " ferr"},  (which == 0) ? rxFerr0  : rxFerr1,  ferr);
    checkOutput({tag, " empty"}, (which == 0) ? rxEmpty0 : rxEmpty1, 1'b0);
  endtask

  task automatic waitTxIdle(input int which, input int budget);
    int n;
    n = 0;
    while (n < budget && ((which == 0) ? txBusy0 : txBusy1)) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tx idle within budget", n < budget, 1);
  endtask

  // Decodes frames on monLine, sampling mid-bit on falling clock edges.
  initial begin : lineMonitor
    logic [7:0] d;
    logic       p, s;
    forever begin
      @(negedge monLine);
      repeat (5) @(negedge clk);
      if (monLine == 1'b0) begin
        d = '0;
        for (int i = 0; i < 8; i++) begin
          repeat (10) @(negedge clk);
          d[i] = monLine;
        end
        p = 1'b0;
        if (monHasPar) begin
          repeat (10) @(negedge clk);
          p = monLine;
        end
        s = 1'b1;
        for (int k = 0; k < monStops; k++) begin
          repeat (10) @(negedge clk);
          s = s & monLine;
        end
        monQ.push_back({s, p, d});
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [7:0] b55;
    logic [7:0] t2Bytes [3];
    logic [7:0] t4Bytes [5];
    logic [9:0] e;
    logic       expBit;

    b55 = 8'h55;
    t2Bytes = '{8'hA5, 8'h3C, 8'hFF};
    t4Bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    checkOutput("rst uart_tx", tx0, 1'b1);
    checkOutput("rst tx_full", txFull0, 1'b0);
    checkOutput("rst tx_busy", txBusy0, 1'b0);
    checkOutput("rst rx_empty", rxEmpty0, 1'b1);
    checkOutput("rst rx_data", rxData0, 8'h00);
    checkOutput("rst perr", rxPerr0, 1'b0);
    checkOutput("rst ferr", rxFerr0, 1'b0);
    checkOutput("rst overrun", ovr0, 1'b0);
    checkOutput("rst u1 uart_tx", tx1, 1'b1);

    // Test 1: 8N1 0x55 waveform; start bit begins the cycle after the pop
    $display("[TB] test 1: 8N1 transmit 0x55");
    applyTxWrite(0, 8'h55);
    checkOutput("t1 pop cycle uart_tx", tx0, 1'b1);
    checkOutput("t1 pop cycle busy", txBusy0, 1'b1);
    for (int bi = 0; bi < 10; bi++) begin
      if (bi == 0)      expBit = 1'b0;
      else if (bi == 9) expBit = 1'b1;
      else              expBit = b55[bi-1];
      @(negedge clk);
      checkOutput($sformatf("t1 bit%0d first cycle", bi), tx0, expBit);
      repeat (9) @(negedge clk);
      checkOutput($sformatf("t1 bit%0d last cycle", bi), tx0, expBit);
    end
    checkOutput("t1 busy at cycle 99", txBusy0, 1'b1);
    @(negedge clk);
    checkOutput("t1 busy at cycle 100", txBusy0, 1'b0);
    checkOutput("t1 line idle", tx0, 1'b1);

    // Test 2: 8E2 loopback of three back-to-back bytes
    $display("[TB] test 2: 8E2 loopback");
    monQ.delete();
    monSel = 1'b1; monHasPar = 1'b1; monStops = 2; loop1 = 1'b1;
    applyTxWrite(1, 8'hA5);
    applyTxWrite(1, 8'h3C);
    applyTxWrite(1, 8'hFF);
    waitTxIdle(1, 1000);
    repeat (20) @(negedge clk);
    checkOutput("t2 frame count", monQ.size(), 3);
    for (int i = 0; i < 3; i++) begin
      e = (i < monQ.size()) ? monQ[i] : 10'h3FF;
      checkOutput($sformatf("t2 line frame%0d {stop,par,data}", i), e, {2'b10, t2Bytes[i]});
    end
    for (int i = 0; i < 3; i++) begin
      checkHead($sformatf("t2 rx%0d", i), 1, t2Bytes[i], 1'b0, 1'b0);
      applyRxPop(1);
    end
    checkOutput("t2 rx empty after pops", rxEmpty1, 1'b1);
    loop1 = 1'b0; monSel = 1'b0; monHasPar = 1'b0; monStops = 1;

    // Test 3: error injection on the 8E receiver
    $display("[TB] test 3: rx parity and framing errors");
    applyRxFrame(1, 8'h81, 1'b1, 1'b1, 1'b1);
    applyRxFrame(1, 8'h42, 1'b1, 1'b0, 1'b0);
    checkHead("t3 parity entry", 1, 8'h81, 1'b1, 1'b0);
    applyRxPop(1);
    checkHead("t3 frame entry", 1, 8'h42, 1'b0, 1'b1);
    applyRxPop(1);
    checkOutput("t3 rx empty", rxEmpty1, 1'b1);
    checkOutput("t3 rx_data zero when empty", rxData1, 8'h00);

    // Test 4: overrun on the 8N1 receiver
    $display("[TB] test 4: rx overrun");
    for (int i = 0; i < 4; i++) applyRxFrame(0, t4Bytes[i], 1'b0, 1'b0, 1'b1);
    checkOutput("t4 no overrun at full", ovr0, 1'b0);
    applyRxFrame(0, t4Bytes[4], 1'b0, 1'b0, 1'b1);
    checkOutput("t4 overrun set", ovr0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkHead($sformatf("t4 rx%0d", i), 0, t4Bytes[i], 1'b0, 1'b0);
      applyRxPop(0);
    end
    checkOutput("t4 rx empty", rxEmpty0, 1'b1);
    checkOutput("t4 overrun sticky", ovr0, 1'b1);
    ovrClr0 = 1'b1;
    @(negedge clk);
    ovrClr0 = 1'b0;
    checkOutput("t4 overrun cleared", ovr0, 1'b0);

    // Test 5: TX FIFO full. The first byte is popped by the engine the cycle
    // after it is written, so 5 writes fill the 4 entries and the 6th is dropped.
    $display("[TB] test 5: tx fifo full");
    monQ.delete();
    for (int i = 0; i < 6; i++) begin
      applyTxWrite(0, 8'hA1 + 8'(i));
      if (i == 3) checkOutput("t5 not full after 4 writes", txFull0, 1'b0);
      if (i == 4) checkOutput("t5 full after 5 writes", txFull0, 1'b1);
    end
    checkOutput("t5 full after dropped write", txFull0, 1'b1);
    waitTxIdle(0, 2000);
    repeat (20) @(negedge clk);
    checkOutput("t5 frame count", monQ.size(), 5);
    for (int i = 0; i < 5; i++) begin
      e = (i < monQ.size()) ? monQ[i] : 10'h3FF;
      checkOutput($sformatf("t5 frame%0d", i), e, {2'b10, 8'hA1 + 8'(i)});
    end

    // Test 6: glitch rejection, then reset in the middle of a data bit
    $display("[TB] test 6: glitch and reset");
    rx0Drive = 1'b0;
    repeat (3) @(negedge clk);
    rx0Drive = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("t6 glitch no push", rxEmpty0, 1'b1);
    applyRxFrame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    checkHead("t6 rx before reset", 0, 8'h5A, 1'b0, 1'b0);
    applyTxWrite(0, 8'h00);
    applyTxWrite(0, 8'h12);
    repeat (14) @(negedge clk);
    checkOutput("t6 mid data bit low", tx0, 1'b0);
    checkOutput("t6 busy before reset", txBusy0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t6 uart_tx after reset", tx0, 1'b1);
    checkOutput("t6 busy after reset", txBusy0, 1'b0);
    checkOutput("t6 tx_full after reset", txFull0, 1'b0);
    checkOutput("t6 rx_empty after reset", rxEmpty0, 1'b1);
    checkOutput("t6 rx_data after reset", rxData0, 8'h00);
    repeat (5) @(negedge clk);
    checkOutput("t6 no restart after reset", tx0, 1'b1);
    checkOutput("t6 still idle after reset", txBusy0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
